// File: rtl/frame_commit_scheduler_if.sv
// Cell-write handshake from game logic into the frame commit scheduler.
interface frame_commit_scheduler_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    modport master (output wr_valid, wr_addr, wr_data, input wr_ready);
    modport slave  (input wr_valid, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/frame_commit_scheduler.sv
// Buffers board-cell writes in a FIFO and commits them to the board RAM only
// during vertical blanking; also provides a frame counter and commit-done pulse.
module frame_commit_scheduler #(
    parameter int WIDTH  = 12,
    parameter int VSIZE  = 600,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int FCNT_W = 16
) (
    input  logic                     clk_vga,
    input  logic                     reset_n,
    input  logic [WIDTH-1:0]         vdata,
    frame_commit_scheduler_if.slave  wr,
    output logic                     ram_we,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [DATA_W-1:0]        ram_wdata,
    output logic                     in_vblank,
    output logic [FCNT_W-1:0]        frame_cnt,
    output logic                     commit_done,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [WIDTH-1:0] VSIZE_V = WIDTH'(VSIZE);
    localparam logic [LW-1:0]    FULL_V  = LW'(DEPTH);

    typedef enum logic [1:0] {ACTIVE, DRAIN, DONE} state_t;
    state_t state;

    logic [ADDR_W+DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]            rd_ptr;
    logic [AW-1:0]            wr_ptr;
    logic [LW-1:0]            count;
    logic                     vblank_now;
    logic                     push;
    logic                     pop;
    logic [ADDR_W-1:0]        head_addr;
    logic [DATA_W-1:0]        head_data;

    assign vblank_now             = (vdata >= VSIZE_V);
    assign wr.wr_ready            = (count != FULL_V);
    assign push                   = wr.wr_valid & wr.wr_ready;
    assign pop                    = (state == DRAIN) & vblank_now & (count != '0);
    assign {head_addr, head_data} = mem[rd_ptr];
    assign fifo_level             = count;

    // Storage needs no reset: pointers and count define validity.
    always_ff @(posedge clk_vga) begin
        if (push) begin
            mem[wr_ptr] <= {wr.wr_addr, wr.wr_data};
        end
    end

    always_ff @(posedge clk_vga) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // in_vblank resets high so leaving reset mid-blank is not seen as an entry.
    always_ff @(posedge clk_vga) begin
        if (!reset_n) begin
            state       <= ACTIVE;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            frame_cnt   <= '0;
            commit_done <= 1'b0;
            in_vblank   <= 1'b1;
        end else begin
            in_vblank   <= vblank_now;
            ram_we      <= 1'b0;
            commit_done <= 1'b0;
            case (state)
                ACTIVE: begin
                    if (vblank_now && !in_vblank) begin
                        frame_cnt <= frame_cnt + FCNT_W'(1);
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!vblank_now) begin
                        state <= ACTIVE;
                    end else if (count != '0) begin
                        ram_we    <= 1'b1;
                        ram_addr  <= head_addr;
                        ram_wdata <= head_data;
                    end else begin
                        commit_done <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (!vblank_now) begin
                        state <= ACTIVE;
                    end
                end
                default: state <= ACTIVE;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_commit_scheduler.sv
// Randomized and directed bench for frame_commit_scheduler, checked against a
// queue-based reference model of the commit rules.
module tb_frame_commit_scheduler;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] vdata = 12'd650;

    logic        ram_we, in_vblank, commit_done;
    logic [8:0]  ram_addr;
    logic [15:0] ram_wdata, frame_cnt;
    logic [3:0]  fifo_level;

    logic        ram_we2, in_vblank2, commit_done2;
    logic [8:0]  ram_addr2;
    logic [15:0] ram_wdata2;
    logic [1:0]  frame_cnt2;
    logic [3:0]  fifo_level2;

    frame_commit_scheduler_if #(.ADDR_W(9), .DATA_W(16)) wif ();
    frame_commit_scheduler_if #(.ADDR_W(9), .DATA_W(16)) wif2 ();

    frame_commit_scheduler #(.DEPTH(DEPTH), .FCNT_W(16)) dut (
        .clk_vga(clk), .reset_n(rst_n), .vdata(vdata), .wr(wif.slave),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .in_vblank(in_vblank), .frame_cnt(frame_cnt), .commit_done(commit_done),
        .fifo_level(fifo_level)
    );

    // Narrow frame counter instance exercises the wrap cheaply.
    frame_commit_scheduler #(.DEPTH(DEPTH), .FCNT_W(2)) dut2 (
        .clk_vga(clk), .reset_n(rst_n), .vdata(vdata), .wr(wif2.slave),
        .ram_we(ram_we2), .ram_addr(ram_addr2), .ram_wdata(ram_wdata2),
        .in_vblank(in_vblank2), .frame_cnt(frame_cnt2), .commit_done(commit_done2),
        .fifo_level(fifo_level2)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [24:0] pend[$];
    logic [24:0] mq[$];
    int          m_phase = 0;
    bit          m_invb = 1'b1, m_we = 1'b0, m_done = 1'b0;
    logic [8:0]  m_addr = '0;
    logic [15:0] m_data = '0;
    int          m_cnt = 0;
    bit          rand_gaps = 1'b0;
    int          nwrites = 0, ndone = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit          vb, rdy, acc;
        logic [24:0] head;
        wif.wr_valid = (pend.size() > 0) && rst_n && (!rand_gaps || $urandom_range(0, 3) != 0);
        if (pend.size() > 0) {wif.wr_addr, wif.wr_data} = pend[0];
        #1;
        rdy = (mq.size() < DEPTH);
        if (rst_n) chk("wr_ready", 32'(wif.wr_ready), 32'(rdy));
        acc = wif.wr_valid && rdy && rst_n;
        vb  = (vdata >= 12'd600);
        if (!rst_n) begin
            mq.delete();
            m_we = 0; m_addr = '0; m_data = '0; m_cnt = 0; m_done = 0; m_invb = 1; m_phase = 0;
        end else begin
            m_we = 0; m_done = 0;
            if (m_phase == 0) begin
                if (vb && !m_invb) begin m_cnt = (m_cnt + 1) % 65536; m_phase = 1; end
            end else if (m_phase == 1) begin
                if (!vb) m_phase = 0;
                else if (mq.size() > 0) begin
                    head = mq.pop_front();
                    m_we = 1; {m_addr, m_data} = head;
                end else begin
                    m_done = 1; m_phase = 2;
                end
            end else if (!vb) m_phase = 0;
            m_invb = vb;
            if (acc) begin mq.push_back(pend[0]); void'(pend.pop_front()); end
        end
        @(posedge clk); #1;
        chk("ram_we", 32'(ram_we), 32'(m_we));
        chk("ram_addr", 32'(ram_addr), 32'(m_addr));
        chk("ram_wdata", 32'(ram_wdata), 32'(m_data));
        chk("commit_done", 32'(commit_done), 32'(m_done));
        chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
        chk("frame_cnt_w2", 32'(frame_cnt2), 32'(m_cnt % 4));
        chk("in_vblank", 32'(in_vblank), 32'(rst_n ? vb : 1'b1));
        if (ram_we === 1'b1) nwrites++;
        if (commit_done === 1'b1) ndone++;
    endtask

    task automatic run(input int v, input int n);
        vdata = 12'(v);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic add(input int a, input int d);
        pend.push_back({9'(a), 16'(d)});
    endtask

    initial begin
        int w0, d0;
        wif.wr_valid = 0; wif.wr_addr = '0; wif.wr_data = '0;
        wif2.wr_valid = 0; wif2.wr_addr = '0; wif2.wr_data = '0;

        // Reset released mid-blank: no false entry
        rst_n = 0; run(650, 3);
        rst_n = 1; run(650, 5);
        chk("midblank_fcnt", 32'(frame_cnt), 32'd0);
        run(100, 3); run(600, 3);
        chk("first_entry_fcnt", 32'(frame_cnt), 32'd1);
        run(620, 3);

        // Three writes committed in order at blanking
        add(5, 16'h0011); add(6, 16'h0022); add(7, 16'h0033);
        run(100, 6);
        w0 = nwrites; d0 = ndone;
        run(600, 8);
        chk("three_writes", 32'(nwrites - w0), 32'd3);
        chk("three_done", 32'(ndone - d0), 32'd1);

        // Overfill: ninth held by source until the first pop
        for (int i = 0; i < 9; i++) add(32 + i, 16'hA000 + i);
        run(100, 12);
        chk("full_level", 32'(fifo_level), 32'd8);
        chk("full_ready", 32'(wif.wr_ready), 32'd0);
        run(600, 15);

        // Blanking cut short after three pops
        for (int i = 0; i < 8; i++) add(64 + i, 16'hB000 + i);
        run(100, 10);
        w0 = nwrites; d0 = ndone;
        run(600, 4);
        run(0, 2);
        chk("partial_level", 32'(fifo_level), 32'd5);
        chk("partial_writes", 32'(nwrites - w0), 32'd3);
        chk("partial_no_done", 32'(ndone - d0), 32'd0);
        run(0, 3); run(600, 10);

        // Push during DRAIN
        add(100, 16'h1); add(101, 16'h2); add(102, 16'h3);
        run(100, 5); run(600, 2);
        add(103, 16'h4);
        run(600, 10);

        // Reset mid-DRAIN discards pending entries
        for (int i = 0; i < 6; i++) add(200 + i, 16'hC000 + i);
        run(100, 8); run(600, 3);
        pend.delete();
        rst_n = 0; step();
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        rst_n = 1;
        w0 = nwrites;
        run(600, 3); run(100, 3); run(600, 6);
        chk("rst_no_stale", 32'(nwrites - w0), 32'd0);

        // Randomized frames
        rand_gaps = 1;
        for (int f = 0; f < 40; f++) begin
            int n;
            n = $urandom_range(0, 10);
            for (int i = 0; i < n; i++) add($urandom_range(0, 511), $urandom_range(0, 65535));
            run($urandom_range(0, 599), $urandom_range(3, 14));
            vdata = 12'($urandom_range(600, 4095));
            for (int i = 0; i < int'($urandom_range(1, 6)); i++) step();
            if ($urandom_range(0, 1) == 1) add($urandom_range(0, 511), $urandom_range(0, 65535));
            run(int'(vdata), $urandom_range(1, 10));
        end
        rand_gaps = 0;
        pend.delete();
        run(100, 4); run(600, 14); run(100, 2);
        chk("final_level", 32'(fifo_level), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
